// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit: funct3 load encodings, the
// controller state encoding and the helpers that classify a load request.
package load_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101
    } ld_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_DONE
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // A load is split when its bytes straddle a word boundary.
    function automatic logic is_split(input logic [2:0] op, input logic [1:0] offset);
        case (op)
            OP_LH, OP_LHU: return (offset == 2'd3);
            OP_LW:         return (offset != 2'd0);
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Bus bundles for the load alignment unit: the core-side load request channel
// and the word-wide data-memory read channel.
interface load_req_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_op;
    logic        ld_done;
    logic        ld_err;
    logic [31:0] ld_data;

    modport master (
        output ld_valid, ld_addr, ld_op,
        input  ld_ready, ld_done, ld_err, ld_data
    );
    modport slave (
        input  ld_valid, ld_addr, ld_op,
        output ld_ready, ld_done, ld_err, ld_data
    );
endinterface

interface load_mem_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_align_unit_extract.sv
// Combinational byte/halfword/word extraction from a little-endian word pair,
// followed by sign or zero extension according to the load funct3.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    logic [63:0] pair_shift;
    logic [31:0] raw;

    always_comb begin
        pair_shift = {hi_i, lo_i} >> {offset_i, 3'b000};
        raw        = pair_shift[31:0];
        case (op_i)
            OP_LB:   data_o = {{24{raw[7]}}, raw[7:0]};
            OP_LBU:  data_o = {24'h0, raw[7:0]};
            OP_LH:   data_o = {{16{raw[15]}}, raw[15:0]};
            OP_LHU:  data_o = {16'h0, raw[15:0]};
            OP_LW:   data_o = raw;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: accepts a load, issues one or two word reads with at most
// one outstanding, and returns the aligned, extended result for one cycle.
module load_align_unit
    import load_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    load_req_if.slave  ld,
    load_mem_if.master mem
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic        err_q, err_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] data_q, data_d;

    logic        split;
    logic [31:0] word_base;
    logic [31:0] ext_hi;
    logic [31:0] ext_lo;
    logic [31:0] ext_data;

    assign split     = is_split(op_q, addr_q[1:0]);
    assign word_base = {addr_q[31:2], 2'b00};

    // Extraction sees the returning word directly so the result can be
    // registered on the same edge that completes the last read.
    assign ext_lo = (state_q == S_WAIT0) ? mem.mem_rdata : lo_q;
    assign ext_hi = (state_q == S_WAIT1) ? mem.mem_rdata : 32'h0;

    load_extract u_extract (
        .hi_i     (ext_hi),
        .lo_i     (ext_lo),
        .offset_i (addr_q[1:0]),
        .op_i     (op_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            op_q    <= 3'b000;
            err_q   <= 1'b0;
            lo_q    <= 32'h0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        err_d   = err_q;
        lo_d    = lo_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (ld.ld_valid) begin
                    addr_d  = ld.ld_addr;
                    op_d    = ld.ld_op;
                    err_d   = !op_legal(ld.ld_op);
                    state_d = op_legal(ld.ld_op) ? S_REQ0 : S_DONE;
                end
            end
            S_REQ0: begin
                if (mem.mem_gnt) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem.mem_rvalid) begin
                    lo_d = mem.mem_rdata;
                    if (split) begin
                        state_d = S_REQ1;
                    end else begin
                        data_d  = ext_data;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ1: begin
                if (mem.mem_gnt) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem.mem_rvalid) begin
                    data_d  = ext_data;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ld.ld_ready  = (state_q == S_IDLE);
    assign ld.ld_done   = (state_q == S_DONE) && !err_q;
    assign ld.ld_err    = (state_q == S_DONE) && err_q;
    assign ld.ld_data   = data_q;

    // Second word address wraps naturally at the top of the address space.
    assign mem.mem_req  = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign mem.mem_addr = ((state_q == S_REQ1) || (state_q == S_WAIT1))
                          ? (word_base + 32'd4) : word_base;

endmodule
